// File: rtl/sort_oddeven_n.sv
// -----------------------------------------------------------------------------
// sort_oddeven_n
//
// Sorts COUNT unsigned DIGIT-bit elements by odd-even transposition. Every pair
// of the active parity is compared and conditionally swapped in the same clock
// cycle, so one phase completes per edge. The block uses a start/busy/done
// handshake. The order is selectable (ascending or descending), and early
// termination is optional. It sits between the operand capture stage and the
// display/result register bank.
//
// Parameters
//   DIGIT       element width in bits (>= 1)
//   COUNT       number of elements (>= 2)
//   EARLY_EXIT  1: stop once an even and an odd phase run back-to-back with no
//               swap; 0: always run COUNT phases
//
// Ports
//   clock    in   1            rising-edge clock
//   reset_n  in   1            asynchronous reset, active low
//   x        in   COUNT*DIGIT  unsorted elements, element i = x[i*DIGIT +: DIGIT]
//   start    in   1            sort request, sampled only while idle
//   descend  in   1            0 ascending (element 0 smallest), 1 descending;
//                              latched together with start
//   s        out  COUNT*DIGIT  working/result elements, same packing as x
//   busy     out  1            high while sorting
//   done     out  1            one-cycle pulse, s holds the final sorted result
// -----------------------------------------------------------------------------
module sort_oddeven_n #(
  parameter int DIGIT      = 4,
  parameter int COUNT      = 4,
  parameter int EARLY_EXIT = 0
) (
  input  logic                   clock,
  input  logic                   reset_n,
  input  logic [COUNT*DIGIT-1:0] x,
  input  logic                   start,
  input  logic                   descend,
  output logic [COUNT*DIGIT-1:0] s,
  output logic                   busy,
  output logic                   done
);

  // The phase counter must be able to reach COUNT without wrapping.
  localparam int              PW         = $clog2(COUNT + 1);
  localparam logic [PW-1:0]   LAST_PHASE = PW'(COUNT - 1);

  typedef enum logic {
    IDLE = 1'b0,
    SORT = 1'b1
  } state_t;

  state_t        state;
  logic [PW-1:0] phase;
  logic          mode;       // latched descend
  logic [1:0]    swap_flag;  // [0]: last even phase swapped, [1]: last odd phase swapped

  logic [DIGIT-1:0]       cur [COUNT];
  logic [DIGIT-1:0]       nxt [COUNT];
  logic [COUNT*DIGIT-1:0] s_next;
  logic                   any_swap;
  logic                   quiet_pair;
  logic                   finish;

  // ---------------------------------------------------------------------------
  // One compare-exchange phase over the whole array.
  // The pairs of one parity never overlap, so all of them can swap in parallel.
  // Lower index i is paired with i+1 when i has the parity of the current phase.
  // An element without a partner (an end element) keeps its value.
  // ---------------------------------------------------------------------------
  always_comb begin
    // NOTE: every combinational output gets a default first, so no path leaves
    // it unassigned and no latch is inferred.
    any_swap = 1'b0;
    s_next   = '0;
    for (int i = 0; i < COUNT; i++) begin
      cur[i] = s[i*DIGIT +: DIGIT];
      nxt[i] = cur[i];
    end
    for (int i = 0; i < COUNT - 1; i++) begin
      if (i[0] == phase[0]) begin
        // The compare is strict, so equal elements never swap.
        if (mode ? (cur[i] < cur[i+1]) : (cur[i] > cur[i+1])) begin
          nxt[i]   = cur[i+1];
          nxt[i+1] = cur[i];
          any_swap = 1'b1;
        end
      end
    end
    for (int i = 0; i < COUNT; i++) begin
      s_next[i*DIGIT +: DIGIT] = nxt[i];
    end
  end

  // Early exit: this phase and the previous phase (other parity) were both
  // swap-free. Both flags start at 1, so this cannot happen before phase 1.
  assign quiet_pair = !any_swap && !swap_flag[~phase[0]];
  assign finish     = (phase == LAST_PHASE) || ((EARLY_EXIT != 0) && quiet_pair);

  // ---------------------------------------------------------------------------
  // Control FSM, working array and registered handshake outputs.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      // NOTE: s is reset even though it is plain data. It is visible on the
      // port, and after a reset it must read as all zeros.
      state     <= IDLE;
      s         <= '0;
      phase     <= '0;
      mode      <= 1'b0;
      swap_flag <= 2'b00;
      busy      <= 1'b0;
      done      <= 1'b0;
    end else begin
      // NOTE: state updates use non-blocking assignments. Every register then
      // samples the pre-edge values, whatever order the statements are in.
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            s         <= x;
            mode      <= descend;
            phase     <= '0;
            swap_flag <= 2'b11;
            busy      <= 1'b1;
            state     <= SORT;
          end
        end
        SORT: begin
          // start, x and descend are not looked at here. A request while busy
          // has no effect on s or on the latched mode.
          s                   <= s_next;
          phase               <= phase + 1'b1;
          swap_flag[phase[0]] <= any_swap;
          if (finish) begin
            busy  <= 1'b0;
            done  <= 1'b1;
            state <= IDLE;
          end
        end
        default: begin
          busy  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_sort_oddeven_n.sv
// -----------------------------------------------------------------------------
// tb_sort_oddeven_n
//
// Three instances share one clock and one reset:
//   dut_a  DIGIT=4, COUNT=4, EARLY_EXIT=0
//   dut_b  DIGIT=4, COUNT=4, EARLY_EXIT=1
//   dut_c  DIGIT=8, COUNT=5, EARLY_EXIT=0
// The stimulus pushes {expected result, expected busy cycles} into a per-DUT
// queue. A monitor per DUT pops and compares on every done pulse.
// -----------------------------------------------------------------------------
module tb_sort_oddeven_n;

  logic clock;
  logic reset_n;

  logic [15:0] x_a, s_a, x_b, s_b;
  logic [39:0] x_c, s_c;
  logic start_a, descend_a, busy_a, done_a;
  logic start_b, descend_b, busy_b, done_b;
  logic start_c, descend_c, busy_c, done_c;

  sort_oddeven_n #(.DIGIT(4), .COUNT(4), .EARLY_EXIT(0)) dut_a (
    .clock(clock), .reset_n(reset_n), .x(x_a), .start(start_a),
    .descend(descend_a), .s(s_a), .busy(busy_a), .done(done_a)
  );

  sort_oddeven_n #(.DIGIT(4), .COUNT(4), .EARLY_EXIT(1)) dut_b (
    .clock(clock), .reset_n(reset_n), .x(x_b), .start(start_b),
    .descend(descend_b), .s(s_b), .busy(busy_b), .done(done_b)
  );

  sort_oddeven_n #(.DIGIT(8), .COUNT(5), .EARLY_EXIT(0)) dut_c (
    .clock(clock), .reset_n(reset_n), .x(x_c), .start(start_c),
    .descend(descend_c), .s(s_c), .busy(busy_c), .done(done_c)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  typedef struct {
    logic [39:0] s;
    int          phases;
  } exp_t;

  exp_t q_a[$];
  exp_t q_b[$];
  exp_t q_c[$];

  int checks   = 0;
  int failures = 0;
  int cnt_a    = 0;
  int cnt_b    = 0;
  int cnt_c    = 0;

  task automatic check(input string name, input logic [39:0] act, input logic [39:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Called by the monitors on every done pulse.
  task automatic on_done(input int which, input logic [39:0] act, input int cnt);
    exp_t e;
    bit   have;
    have = 1'b0;
    case (which)
      0: if (q_a.size() > 0) begin e = q_a.pop_front(); have = 1'b1; end
      1: if (q_b.size() > 0) begin e = q_b.pop_front(); have = 1'b1; end
      default: if (q_c.size() > 0) begin e = q_c.pop_front(); have = 1'b1; end
    endcase
    if (!have) begin
      checks++;
      failures++;
      $display("FAIL dut%0d_unexpected_done: got done with s=%0h expected no done", which, act);
    end else begin
      check($sformatf("dut%0d_result", which), act, e.s);
      check($sformatf("dut%0d_busy_cycles", which), 40'(cnt), 40'(e.phases));
    end
  endtask

  // Monitors: count busy cycles since the last done, and score each done.
  always @(negedge clock) begin
    if (!reset_n) cnt_a = 0;
    else begin
      if (busy_a) cnt_a++;
      if (done_a) begin on_done(0, 40'(s_a), cnt_a); cnt_a = 0; end
    end
  end

  always @(negedge clock) begin
    if (!reset_n) cnt_b = 0;
    else begin
      if (busy_b) cnt_b++;
      if (done_b) begin on_done(1, 40'(s_b), cnt_b); cnt_b = 0; end
    end
  end

  always @(negedge clock) begin
    if (!reset_n) cnt_c = 0;
    else begin
      if (busy_c) cnt_c++;
      if (done_c) begin on_done(2, s_c, cnt_c); cnt_c = 0; end
    end
  end

  // Drives a one-cycle start pulse from the current negedge and optionally
  // records the expectation. The task returns at the negedge after the
  // accepting edge.
  task automatic issue(input int which, input logic [39:0] xv, input logic d,
                       input logic [39:0] es, input int ph, input bit push);
    exp_t e;
    e.s      = es;
    e.phases = ph;
    case (which)
      0: begin x_a = xv[15:0]; descend_a = d; start_a = 1'b1; if (push) q_a.push_back(e); end
      1: begin x_b = xv[15:0]; descend_b = d; start_b = 1'b1; if (push) q_b.push_back(e); end
      default: begin x_c = xv; descend_c = d; start_c = 1'b1; if (push) q_c.push_back(e); end
    endcase
    @(negedge clock);
    start_a = 1'b0;
    start_b = 1'b0;
    start_c = 1'b0;
  endtask

  // Waits, up to a budget of cycles, for a done pulse. Returns at the negedge
  // where done is high.
  task automatic wait_done(input int which, input int budget);
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < budget && !seen; i++) begin
      @(negedge clock);
      case (which)
        0: seen = done_a;
        1: seen = done_b;
        default: seen = done_c;
      endcase
    end
    if (!seen) begin
      checks++;
      failures++;
      $display("FAIL dut%0d_timeout: got no done expected done within %0d cycles", which, budget);
    end
  endtask

  initial begin
    reset_n   = 1'b0;
    x_a = '0; x_b = '0; x_c = '0;
    start_a = 1'b0; start_b = 1'b0; start_c = 1'b0;
    descend_a = 1'b0; descend_b = 1'b0; descend_c = 1'b0;

    // Reset state
    #3;
    check("reset_s_a", 40'(s_a), 40'h0);
    check("reset_busy_a", 40'(busy_a), 40'h0);
    check("reset_done_a", 40'(done_a), 40'h0);
    check("reset_s_b", 40'(s_b), 40'h0);
    check("reset_busy_b", 40'(busy_b), 40'h0);
    check("reset_s_c", s_c, 40'h0);
    check("reset_busy_c", 40'(busy_c), 40'h0);
    @(negedge clock);
    reset_n = 1'b1;
    @(negedge clock);

    // Test 1: {3,1,2,0} ascending -> {0,1,2,3}, 4 busy cycles
    issue(0, 40'h0213, 1'b0, 40'h3210, 4, 1'b1);
    wait_done(0, 20);
    repeat (3) @(negedge clock);
    check("a_result_holds_idle", 40'(s_a), 40'h3210);
    check("a_idle_busy", 40'(busy_a), 40'h0);

    // Test 2: same input, descending -> {3,2,1,0}
    issue(0, 40'h0213, 1'b1, 40'h0123, 4, 1'b1);
    wait_done(0, 20);
    @(negedge clock);

    // Test 3: duplicates {5,5,0,5} ascending -> {0,5,5,5}
    issue(0, 40'h5055, 1'b0, 40'h5550, 4, 1'b1);
    wait_done(0, 20);
    @(negedge clock);

    // Test 4: pre-sorted input, early exit after 2 phases vs. fixed 4 phases
    issue(1, 40'h3210, 1'b0, 40'h3210, 2, 1'b1);
    wait_done(1, 20);
    @(negedge clock);
    issue(0, 40'h3210, 1'b0, 40'h3210, 4, 1'b1);
    wait_done(0, 20);
    @(negedge clock);
    // Early-exit instance on data that keeps swapping until the end
    issue(1, 40'h0213, 1'b0, 40'h3210, 4, 1'b1);
    wait_done(1, 20);
    @(negedge clock);
    issue(1, 40'h0213, 1'b1, 40'h0123, 4, 1'b1);
    wait_done(1, 20);
    @(negedge clock);

    // Test 6: COUNT=5, DIGIT=8, {200,7,7,255,0}
    issue(2, {8'd0, 8'd255, 8'd7, 8'd7, 8'd200}, 1'b0,
          {8'd255, 8'd200, 8'd7, 8'd7, 8'd0}, 5, 1'b1);
    wait_done(2, 20);
    @(negedge clock);
    issue(2, {8'd0, 8'd255, 8'd7, 8'd7, 8'd200}, 1'b1,
          {8'd0, 8'd7, 8'd7, 8'd200, 8'd255}, 5, 1'b1);
    wait_done(2, 20);
    @(negedge clock);

    // Test 5a: start again with new x and descend during SORT -> ignored
    issue(0, 40'h0213, 1'b0, 40'h3210, 4, 1'b1);
    x_a       = 16'hFFFF;
    descend_a = 1'b1;
    start_a   = 1'b1;
    @(negedge clock);
    start_a = 1'b0;
    x_a     = 16'h1234;
    wait_done(0, 20);
    @(negedge clock);

    // Test 5b: start in the done cycle is accepted
    issue(0, 40'h5055, 1'b0, 40'h5550, 4, 1'b1);
    wait_done(0, 20);
    issue(0, 40'h0213, 1'b1, 40'h0123, 4, 1'b1);
    check("a_done_drops_after_restart", 40'(done_a), 40'h0);
    check("a_busy_after_restart", 40'(busy_a), 40'h1);
    wait_done(0, 20);
    @(negedge clock);

    // Test 5c: asynchronous reset mid-sort; the aborted sort must never signal done
    issue(0, 40'h0213, 1'b0, 40'h0, 0, 1'b0);
    @(negedge clock);
    #2;
    reset_n = 1'b0;
    #1;
    check("a_async_reset_s", 40'(s_a), 40'h0);
    check("a_async_reset_busy", 40'(busy_a), 40'h0);
    check("a_async_reset_done", 40'(done_a), 40'h0);
    @(negedge clock);
    reset_n = 1'b1;
    repeat (10) @(negedge clock);
    check("a_idle_after_abort", 40'(busy_a), 40'h0);

    // Every expectation must have been consumed.
    check("a_queue_empty", 40'(q_a.size()), 40'h0);
    check("b_queue_empty", 40'(q_b.size()), 40'h0);
    check("c_queue_empty", 40'(q_c.size()), 40'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
